// File: rtl/upsizer_out_register.sv
// Output holding register for the upsizer: one wide word plus its valid flag,
// reloadable in the same cycle the downstream consumes the current word.
module upsizer_out_register #(
    parameter int DATA_WIDTH = 128
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  can_load,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready
);

    // Free to take a new word when empty or when the held word leaves this cycle.
    assign can_load = ~m_axis_tvalid | m_axis_tready;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
        end else if (load) begin
            m_axis_tdata  <= load_data;
            m_axis_tvalid <= 1'b1;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_upsizer.sv
// AXI-Stream width upsizer: packs up to M/S narrow words (LSB first) into one
// wide word; the number of words per beat is set at run time by cfg_data.
module axis_upsizer #(
    parameter int S_AXIS_TDATA_WIDTH = 32,
    parameter int M_AXIS_TDATA_WIDTH = 128
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [15:0]                   cfg_data,
    input  logic [S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    output logic [M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready
);

    localparam int RATIO      = M_AXIS_TDATA_WIDTH / S_AXIS_TDATA_WIDTH;
    localparam int CNTR_WIDTH = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNTR_WIDTH-1:0] MAX_IDX = CNTR_WIDTH'(RATIO - 1);

    logic [CNTR_WIDTH-1:0]         cntr;
    logic [CNTR_WIDTH-1:0]         cfg_idx;
    logic [CNTR_WIDTH-1:0]         last_idx;
    logic [M_AXIS_TDATA_WIDTH-1:0] accum;
    logic [M_AXIS_TDATA_WIDTH-1:0] merged;
    logic                          is_last;
    logic                          xfer;
    logic                          can_load;
    logic                          unused_cfg;

    assign unused_cfg = ^cfg_data;
    assign cfg_idx    = cfg_data[CNTR_WIDTH-1:0];
    assign last_idx   = (cfg_idx > MAX_IDX) ? MAX_IDX : cfg_idx;

    // ">=" rather than "==" so a cfg lowered below the current count ends the beat now.
    assign is_last       = (cntr >= last_idx);
    assign s_axis_tready = ~areset & (~is_last | can_load);
    assign xfer          = s_axis_tvalid & s_axis_tready;

    always_comb begin
        merged = accum;
        for (int i = 0; i < RATIO; i++) begin
            if (i == int'(cntr)) begin
                merged[i*S_AXIS_TDATA_WIDTH +: S_AXIS_TDATA_WIDTH] = s_axis_tdata;
            end else if (i > int'(cntr)) begin
                merged[i*S_AXIS_TDATA_WIDTH +: S_AXIS_TDATA_WIDTH] = '0;
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            cntr  <= '0;
            accum <= '0;
        end else if (xfer) begin
            if (is_last) begin
                cntr  <= '0;
                accum <= '0;
            end else begin
                cntr  <= cntr + 1'b1;
                accum <= merged;
            end
        end
    end

    upsizer_out_register #(
        .DATA_WIDTH(M_AXIS_TDATA_WIDTH)
    ) u_out_register (
        .aclk         (aclk),
        .areset       (areset),
        .load         (xfer & is_last),
        .load_data    (merged),
        .can_load     (can_load),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready)
    );

endmodule

// File: tb/tb_axis_upsizer.sv
// Directed and randomized checks of axis_upsizer against beats built from the
// offered words with plain slice arithmetic.
module tb_axis_upsizer;

    localparam int SW = 32;
    localparam int MW = 128;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic [15:0]   cfg_data = 16'd3;
    logic [SW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic [MW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;

    int            assertCount = 0;
    int            failCount = 0;
    bit            randReady = 1'b0;
    logic [MW-1:0] got_q[$];
    logic [SW-1:0] words[400];

    axis_upsizer #(
        .S_AXIS_TDATA_WIDTH(SW),
        .M_AXIS_TDATA_WIDTH(MW)
    ) dut (
        .aclk         (aclk),
        .areset       (areset),
        .cfg_data     (cfg_data),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready)
    );

    always #5 aclk = ~aclk;

    // Record every master handshake; inputs change only just after posedge.
    always @(negedge aclk) begin
        if (!areset && m_axis_tvalid && m_axis_tready) got_q.push_back(m_axis_tdata);
    end

    task automatic checkOutput(input string tag, input logic [MW-1:0] observed,
                               input logic [MW-1:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Offer one word and return just after the edge where it was accepted.
    task automatic applyStimulus(input logic [SW-1:0] w);
        bit done = 1'b0;
        s_axis_tdata  = w;
        s_axis_tvalid = 1'b1;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge aclk);
            if (s_axis_tready) done = 1'b1;
            @(posedge aclk);
            #1;
            if (randReady) m_axis_tready = 1'($urandom_range(0, 1));
        end
        if (!done) checkOutput("send_timeout", MW'(s_axis_tready), MW'(1));
    endtask

    task automatic idle(input int n);
        s_axis_tvalid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge aclk);
            #1;
        end
    endtask

    initial begin
        logic [MW-1:0] beat1;
        logic [MW-1:0] beat2;
        logic [MW-1:0] exp_beat;

        // Reset state
        #2;
        checkOutput("reset_s_tready", MW'(s_axis_tready), MW'(0));
        checkOutput("reset_m_tvalid", MW'(m_axis_tvalid), MW'(0));
        checkOutput("reset_m_tdata", m_axis_tdata, '0);
        @(posedge aclk); @(posedge aclk); #1;
        areset = 1'b0;
        @(negedge aclk);
        checkOutput("release_s_tready", MW'(s_axis_tready), MW'(1));
        @(posedge aclk); #1;

        // Four words back to back, cfg=3
        cfg_data = 16'd3;
        applyStimulus(32'h11111111);
        applyStimulus(32'h22222222);
        applyStimulus(32'h33333333);
        checkOutput("b2b_valid_before", MW'(m_axis_tvalid), MW'(0));
        applyStimulus(32'h44444444);
        s_axis_tvalid = 1'b0;
        checkOutput("b2b_valid", MW'(m_axis_tvalid), MW'(1));
        checkOutput("b2b_data", m_axis_tdata, 128'h44444444333333332222222211111111);
        @(posedge aclk); #1;
        checkOutput("b2b_valid_drop", MW'(m_axis_tvalid), MW'(0));

        // Two words per beat
        cfg_data = 16'd1;
        applyStimulus(32'h0000000A);
        applyStimulus(32'h0000000B);
        s_axis_tvalid = 1'b0;
        checkOutput("cfg1_data", m_axis_tdata, 128'h0000000000000000_0000000B0000000A);

        // One word per beat
        cfg_data = 16'd0;
        applyStimulus(32'hDEADBEEF);
        s_axis_tvalid = 1'b0;
        checkOutput("cfg0_data", m_axis_tdata, 128'h000000000000000000000000DEADBEEF);
        applyStimulus(32'hCAFEF00D);
        s_axis_tvalid = 1'b0;
        checkOutput("cfg0_data2", m_axis_tdata, 128'h000000000000000000000000CAFEF00D);
        idle(3);

        // Backpressure: second beat's last word waits for m_axis_tready
        got_q.delete();
        cfg_data = 16'd3;
        m_axis_tready = 1'b0;
        beat1 = 128'h0000000400000003_0000000200000001;
        beat2 = 128'h0000000800000007_0000000600000005;
        for (int i = 1; i <= 7; i++) applyStimulus(SW'(i));
        s_axis_tdata  = 32'h00000008;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            checkOutput("bp_s_tready_low", MW'(s_axis_tready), MW'(0));
            checkOutput("bp_hold_valid", MW'(m_axis_tvalid), MW'(1));
            checkOutput("bp_hold_data", m_axis_tdata, beat1);
            @(posedge aclk); #1;
        end
        m_axis_tready = 1'b1;
        @(negedge aclk);
        checkOutput("bp_s_tready_high", MW'(s_axis_tready), MW'(1));
        @(posedge aclk); #1;
        s_axis_tvalid = 1'b0;
        checkOutput("bp_reload_valid", MW'(m_axis_tvalid), MW'(1));
        checkOutput("bp_reload_data", m_axis_tdata, beat2);
        @(posedge aclk); #1;
        checkOutput("bp_drain_valid", MW'(m_axis_tvalid), MW'(0));
        checkOutput("bp_beats", MW'(got_q.size()), MW'(2));
        if (got_q.size() == 2) begin
            checkOutput("bp_beat1", got_q[0], beat1);
            checkOutput("bp_beat2", got_q[1], beat2);
        end

        // Lowering cfg mid-beat ends the beat on the next word
        cfg_data = 16'd3;
        applyStimulus(32'hAAAA0000);
        applyStimulus(32'hAAAA0001);
        cfg_data = 16'd0;
        applyStimulus(32'hAAAA0002);
        s_axis_tvalid = 1'b0;
        checkOutput("cfg_drop_valid", MW'(m_axis_tvalid), MW'(1));
        checkOutput("cfg_drop_data", m_axis_tdata, 128'h00000000AAAA0002_AAAA0001AAAA0000);
        idle(2);

        // Reset mid-beat with a beat pending
        cfg_data = 16'd3;
        m_axis_tready = 1'b0;
        for (int i = 0; i < 6; i++) applyStimulus(32'hBB000000 + SW'(i));
        s_axis_tvalid = 1'b0;
        checkOutput("rst_pending_valid", MW'(m_axis_tvalid), MW'(1));
        areset = 1'b1;
        #1;
        checkOutput("rst_m_tvalid", MW'(m_axis_tvalid), MW'(0));
        checkOutput("rst_m_tdata", m_axis_tdata, '0);
        checkOutput("rst_s_tready", MW'(s_axis_tready), MW'(0));
        @(posedge aclk); #1;
        areset = 1'b0;
        m_axis_tready = 1'b1;
        applyStimulus(32'hC0000000);
        applyStimulus(32'hC0000001);
        applyStimulus(32'hC0000002);
        applyStimulus(32'hC0000003);
        s_axis_tvalid = 1'b0;
        checkOutput("rst_after_data", m_axis_tdata, 128'hC0000003C0000002_C0000001C0000000);
        idle(3);

        // Random words with random downstream readiness; upper cfg bits must be ignored
        got_q.delete();
        cfg_data = 16'hFFF7;
        for (int i = 0; i < 400; i++) words[i] = $urandom;
        randReady = 1'b1;
        for (int i = 0; i < 400; i++) begin
            applyStimulus(words[i]);
            if ($urandom_range(0, 3) == 0) begin
                s_axis_tvalid = 1'b0;
                @(posedge aclk); #1;
                m_axis_tready = 1'($urandom_range(0, 1));
            end
        end
        s_axis_tvalid = 1'b0;
        for (int n = 0; n < 2000 && got_q.size() < 100; n++) begin
            @(posedge aclk); #1;
            m_axis_tready = 1'($urandom_range(0, 1));
        end
        randReady = 1'b0;
        m_axis_tready = 1'b1;
        idle(5);
        checkOutput("rand_beat_count", MW'(got_q.size()), MW'(100));
        for (int k = 0; k < 100 && k < got_q.size(); k++) begin
            exp_beat = '0;
            for (int j = 0; j < 4; j++) exp_beat[j*SW +: SW] = words[4*k + j];
            checkOutput($sformatf("rand_beat_%0d", k), got_q[k], exp_beat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
